mem_readout_sched: RTL and testbench

//  Read-out scheduler for the 12-port memory-to-stream path. At each BX boundary it loads per-port entry counts.
//  It then walks the ports in fixed priority (lowest index first), draining each port fully before the next.
//  Per read it drives the one-hot memory read enable and the read address, plus the BX tag and binary port select
//    for the downstream 12:1 output mux, with the select aligned to memory data.

---
 rtl/mem_readout_pkg.sv | 22 ++
 rtl/prio_encoder.sv | 27 ++
 rtl/mem_readout_sched.sv | 195 +++++++++++++++++++
 tb/tb_mem_readout_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_readout_pkg.sv
// Shared parameters and types for the memory read-out scheduler.
//   NPORTS     : number of memory ports feeding the 12:1 output mux
//   NENT_W     : entry-count / read-pointer width
//   BX_W       : BX tag width, also the memory page-select width
//   MEM_RD_LAT : cycles from rd_addr to data valid at the mux input
//   SEL_W      : width of the binary port select
package mem_readout_pkg;

  localparam int unsigned NPORTS     = 12;
  localparam int unsigned NENT_W     = 6;
  localparam int unsigned BX_W       = 3;
  localparam int unsigned MEM_RD_LAT = 1;
  localparam int unsigned SEL_W      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/prio_encoder.sv
// Lowest-index-first priority encoder.
//   req : request vector, bit 0 has the highest priority
//   any : at least one request is set
//   idx : binary index of the lowest set request bit (0 when none)
module prio_encoder
  import mem_readout_pkg::*;
#(
  parameter int unsigned N    = NPORTS,
  parameter int unsigned IdxW = SEL_W
) (
  input  logic [N-1:0]    req,
  output logic            any,
  output logic [IdxW-1:0] idx
);

  always_comb begin
    any = |req;
    idx = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/mem_readout_sched.sv
// Read-out scheduler for the memory-to-stream path.
// On start it latches the read page (bx_in-1) and per-port entry counts, then issues one
// memory read per cycle, draining ports in ascending index order.
//   clk, reset_n : clock, synchronous active-low reset
//   start        : one-cycle pulse at a BX boundary
//   bx_in        : BX currently being written; the previous page is read
//   nent         : packed per-port entry counts, port i at [i*NENT_W +: NENT_W]
//   rd_en        : one-hot memory read enable
//   rd_addr      : {read BX page, entry pointer}
//   mux_sel      : binary port select for the output mux, aligned to memory data
//   mux_bx       : read BX tag, aligned with mux_sel
//   stream_valid : mux output word valid
//   busy         : scheduler in LOAD/RUN/DRAIN
//   done         : pulse once the last valid word has left the mux
//   truncated    : pulse when start aborts an unfinished read-out
module mem_readout_sched
  import mem_readout_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [BX_W-1:0]          bx_in,
  input  logic [NPORTS*NENT_W-1:0] nent,
  output logic [NPORTS-1:0]        rd_en,
  output logic [BX_W+NENT_W-1:0]   rd_addr,
  output logic [SEL_W-1:0]         mux_sel,
  output logic [BX_W-1:0]          mux_bx,
  output logic                     stream_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     truncated
);

  localparam int unsigned DrainW    = $clog2(MEM_RD_LAT + 1) + 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(MEM_RD_LAT);

  state_e                   state_q, state_d;
  logic [BX_W-1:0]          bx_rd_q, bx_rd_d;
  logic [NENT_W-1:0]        rem_q [NPORTS];
  logic [NENT_W-1:0]        rem_d [NPORTS];
  logic [NENT_W-1:0]        ptr_q [NPORTS];
  logic [NENT_W-1:0]        ptr_d [NPORTS];
  logic [NPORTS-1:0]        rd_en_q, rd_en_d;
  logic [BX_W+NENT_W-1:0]   rd_addr_q, rd_addr_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic                     done_q, done_d;
  logic                     trunc_q, trunc_d;
  logic [DrainW-1:0]        drain_cnt_q, drain_cnt_d;

  logic [NPORTS-1:0]        pend;
  logic                     pend_any;
  logic [SEL_W-1:0]         pend_idx;

  // Delay pipes from the read issue point to the mux.
  logic [SEL_W-1:0]         sel_pipe_q [MEM_RD_LAT];
  logic [BX_W-1:0]          bx_pipe_q  [MEM_RD_LAT];
  logic [MEM_RD_LAT:0]      vld_pipe_q;

  always_comb begin
    pend = '0;
    for (int i = 0; i < NPORTS; i++) begin
      pend[i] = (rem_q[i] != '0);
    end
  end

  prio_encoder #(
    .N    (NPORTS),
    .IdxW (SEL_W)
  ) u_prio (
    .req (pend),
    .any (pend_any),
    .idx (pend_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bx_rd_q     <= '0;
      rd_en_q     <= '0;
      rd_addr_q   <= '0;
      sel_q       <= '0;
      done_q      <= 1'b0;
      trunc_q     <= 1'b0;
      drain_cnt_q <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        rem_q[i] <= '0;
        ptr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      bx_rd_q     <= bx_rd_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      sel_q       <= sel_d;
      done_q      <= done_d;
      trunc_q     <= trunc_d;
      drain_cnt_q <= drain_cnt_d;
      rem_q       <= rem_d;
      ptr_q       <= ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bx_rd_d     = bx_rd_q;
    rem_d       = rem_q;
    ptr_d       = ptr_q;
    rd_en_d     = '0;
    rd_addr_d   = rd_addr_q;
    sel_d       = sel_q;
    done_d      = 1'b0;
    trunc_d     = 1'b0;
    drain_cnt_d = drain_cnt_q;

    unique case (state_q)
      StIdle: begin
      end
      StLoad: begin
        for (int i = 0; i < NPORTS; i++) begin
          rem_d[i] = nent[i*NENT_W +: NENT_W];
          ptr_d[i] = '0;
        end
        state_d = StRun;
      end
      StRun: begin
        if (pend_any) begin
          for (int i = 0; i < NPORTS; i++) begin
            if (pend_idx == SEL_W'(i)) begin
              rd_en_d[i] = 1'b1;
              rd_addr_d  = {bx_rd_q, ptr_q[i]};
              rem_d[i]   = rem_q[i] - 1'b1;
              ptr_d[i]   = ptr_q[i] + 1'b1;
            end
          end
          sel_d = pend_idx;
        end else begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end
      end
      StDrain: begin
        if (drain_cnt_q == DrainLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // start wins over everything: abandon the current read-out and reload.
    if (start) begin
      // In LOAD the counts about to be latched stand in for the remaining counts.
      trunc_d     = ((state_q == StLoad) && (|nent)) || ((state_q == StRun) && pend_any);
      rem_d       = rem_q;
      ptr_d       = ptr_q;
      rd_en_d     = '0;
      rd_addr_d   = rd_addr_q;
      sel_d       = sel_q;
      done_d      = 1'b0;
      drain_cnt_d = drain_cnt_q;
      bx_rd_d     = bx_in - 1'b1;
      state_d     = StLoad;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      for (int i = 0; i < MEM_RD_LAT; i++) begin
        sel_pipe_q[i] <= '0;
        bx_pipe_q[i]  <= '0;
      end
    end else begin
      vld_pipe_q    <= {vld_pipe_q[MEM_RD_LAT-1:0], |rd_en_q};
      sel_pipe_q[0] <= sel_q;
      bx_pipe_q[0]  <= bx_rd_q;
      for (int i = 1; i < MEM_RD_LAT; i++) begin
        sel_pipe_q[i] <= sel_pipe_q[i-1];
        bx_pipe_q[i]  <= bx_pipe_q[i-1];
      end
    end
  end

  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign mux_sel      = sel_pipe_q[MEM_RD_LAT-1];
  assign mux_bx       = bx_pipe_q[MEM_RD_LAT-1];
  assign stream_valid = vld_pipe_q[MEM_RD_LAT];
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign truncated    = trunc_q;

endmodule

// File: tb/tb_mem_readout_sched.sv
module tb_mem_readout_sched;
  import mem_readout_pkg::*;

  localparam int unsigned NW = NPORTS * NENT_W;
  localparam int unsigned AW = BX_W + NENT_W;

  typedef struct {
    logic [BX_W-1:0]  bx;
    logic [NW-1:0]    nent;
    int               reads;
    logic [BX_W-1:0]  bx_rd;
    logic [SEL_W-1:0] last_sel;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [BX_W-1:0]   bx_in;
  logic [NW-1:0]     nent;
  logic [NPORTS-1:0] rd_en;
  logic [AW-1:0]     rd_addr;
  logic [SEL_W-1:0]  mux_sel;
  logic [BX_W-1:0]   mux_bx;
  logic              stream_valid;
  logic              busy;
  logic              done;
  logic              truncated;

  mem_readout_sched dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .bx_in        (bx_in),
    .nent         (nent),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .mux_sel      (mux_sel),
    .mux_bx       (mux_bx),
    .stream_valid (stream_valid),
    .busy         (busy),
    .done         (done),
    .truncated    (truncated)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, longint got, longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endfunction

  function automatic logic [NW-1:0] pk(int p, logic [NENT_W-1:0] v);
    logic [NW-1:0] r;
    r = '0;
    r[p*NENT_W +: NENT_W] = v;
    return r;
  endfunction

  function automatic logic [NPORTS+AW-1:0] rd_word(int p, logic [BX_W-1:0] b, int j);
    logic [NPORTS-1:0] oh;
    oh = '0;
    oh[p] = 1'b1;
    return {oh, b, NENT_W'(j)};
  endfunction

  // Observed events, collected on the falling edge.
  logic [NPORTS+AW-1:0]  obs_rd[$];
  logic [SEL_W+BX_W-1:0] obs_mux[$];
  int n_done, n_trunc, n_busy, n_valid, done_cyc, trunc_cyc, start_cyc;
  int cyc = 0;
  logic r1 = 1'b0, r2 = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      r1 = 1'b0;
      r2 = 1'b0;
    end else begin
      check("stream_valid_align", stream_valid, r2);
      if (stream_valid) n_valid++;
      if (r1) obs_mux.push_back({mux_sel, mux_bx});
      if (|rd_en) begin
        check("rd_en_onehot", $onehot(rd_en), 1);
        obs_rd.push_back({rd_en, rd_addr});
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (truncated) begin
        n_trunc++;
        trunc_cyc = cyc;
      end
      if (busy) n_busy++;
      r2 = r1;
      r1 = |rd_en;
    end
  end

  task automatic clear_obs();
    obs_rd.delete();
    obs_mux.delete();
    n_done = 0; n_trunc = 0; n_busy = 0; n_valid = 0;
    done_cyc = 0; trunc_cyc = 0;
  endtask

  // Called just after a falling edge; start is sampled on the next rising edge.
  task automatic kick(logic [BX_W-1:0] b, logic [NW-1:0] nv);
    bx_in = b;
    nent = nv;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string tag, int target, int budget);
    for (int i = 0; i < budget && n_done < target; i++) begin
      @(negedge clk); #1;
    end
    check({tag, "_done_seen"}, n_done >= target, 1);
  endtask

  task automatic run_vec(vec_t v, int k);
    string t;
    int idx;
    t = $sformatf("vec%0d", k);
    clear_obs();
    kick(v.bx, v.nent);
    wait_done(t, 1, 2000);
    repeat (3) begin @(negedge clk); #1; end
    check({t, "_reads"}, obs_rd.size(), v.reads);
    check({t, "_valid_words"}, n_valid, v.reads);
    check({t, "_done_count"}, n_done, 1);
    check({t, "_done_latency"}, done_cyc - start_cyc, v.reads + 5);
    check({t, "_busy_cycles"}, n_busy, v.reads + 4);
    check({t, "_truncated"}, n_trunc, 0);
    check({t, "_busy_after"}, busy, 0);
    check({t, "_mux_sel_hold"}, mux_sel, v.last_sel);
    idx = 0;
    for (int p = 0; p < NPORTS; p++) begin
      for (int j = 0; j < int'(v.nent[p*NENT_W +: NENT_W]); j++) begin
        if (idx < obs_rd.size()) begin
          check({t, "_rd"}, obs_rd[idx], rd_word(p, v.bx_rd, j));
          check({t, "_mux"}, obs_mux[idx], {SEL_W'(p), v.bx_rd});
        end
        idx++;
      end
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{bx: 3'd3, nent: pk(0, 6'd2) | pk(5, 6'd1), reads: 3, bx_rd: 3'd2, last_sel: 4'd5};
    vecs[1] = '{bx: 3'd0, nent: pk(11, 6'd1), reads: 1, bx_rd: 3'd7, last_sel: 4'd11};
    vecs[2] = '{bx: 3'd5, nent: '0, reads: 0, bx_rd: 3'd4, last_sel: 4'd11};
    vecs[3] = '{bx: 3'd1, nent: {NPORTS{6'd63}}, reads: 756, bx_rd: 3'd0, last_sel: 4'd11};
    vecs[4] = '{bx: 3'd6, nent: pk(10, 6'd3) | pk(3, 6'd2) | pk(1, 6'd1), reads: 6,
                bx_rd: 3'd5, last_sel: 4'd10};

    // Reset held with start asserted.
    reset_n = 1'b0;
    start = 1'b1;
    bx_in = '0;
    nent = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_mux_sel", mux_sel, 0);
    check("rst_mux_bx", mux_bx, 0);
    check("rst_stream_valid", stream_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_truncated", truncated, 0);
    reset_n = 1'b1;
    start = 1'b0;
    clear_obs();
    repeat (3) begin @(negedge clk); #1; end
    check("idle_busy", n_busy, 0);
    check("idle_reads", obs_rd.size(), 0);

    for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

    // Abort a long read-out after 10 reads.
    clear_obs();
    kick(3'd2, pk(2, 6'd40));
    for (int i = 0; i < 100 && obs_rd.size() < 10; i++) begin @(negedge clk); #1; end
    check("abort_ten_reads", obs_rd.size(), 10);
    kick(3'd4, pk(1, 6'd1));
    wait_done("abort", 1, 200);
    repeat (3) begin @(negedge clk); #1; end
    check("abort_trunc_count", n_trunc, 1);
    check("abort_trunc_latency", trunc_cyc - start_cyc, 1);
    check("abort_reads", obs_rd.size(), 11);
    check("abort_valid_words", n_valid, 11);
    check("abort_done_count", n_done, 1);
    if (obs_rd.size() == 11 && obs_mux.size() == 11) begin
      for (int j = 0; j < 10; j++) begin
        check("abort_old_rd", obs_rd[j], rd_word(2, 3'd1, j));
        check("abort_old_mux", obs_mux[j], {4'd2, 3'd1});
      end
      check("abort_new_rd", obs_rd[10], rd_word(1, 3'd3, 0));
      check("abort_new_mux", obs_mux[10], {4'd1, 3'd3});
    end

    // start in the same cycle as done.
    clear_obs();
    kick(3'd5, '0);
    wait_done("coinc1", 1, 50);
    kick(3'd1, pk(4, 6'd1));
    check("coinc_busy_load", busy, 1);
    wait_done("coinc2", 2, 50);
    repeat (3) begin @(negedge clk); #1; end
    check("coinc_trunc", n_trunc, 0);
    check("coinc_done_count", n_done, 2);
    check("coinc_latency", done_cyc - start_cyc, 6);
    check("coinc_reads", obs_rd.size(), 1);
    if (obs_rd.size() == 1) check("coinc_rd", obs_rd[0], rd_word(4, 3'd0, 0));

    // Reset in the middle of a read-out.
    clear_obs();
    kick(3'd3, pk(7, 6'd20));
    repeat (5) begin @(negedge clk); #1; end
    reset_n = 1'b0;
    @(negedge clk); #1;
    reset_n = 1'b1;
    repeat (8) begin @(negedge clk); #1; end
    check("midrst_reads", obs_rd.size(), 4);
    check("midrst_done", n_done, 0);
    check("midrst_trunc", n_trunc, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rd_en", rd_en, 0);
    check("midrst_mux_sel", mux_sel, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
